// File: rtl/mem_resp_unit.sv
// Load/store responder: region decode, byte-masked SRAM stores, sign/zero-extended loads.
// Latency READ_LAT+1 (loads) or 2 (stores/errors); one request in flight, req_ready only in IDLE; MMIO_COUNTERS_EN adds counters.
module mem_resp_unit #(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [2:0]  funct3;
  } req_t;

  logic [1:0]  state;
  logic [1:0]  latCnt;
  req_t        rq;
  logic [31:0] rdWord;
  logic [31:0] mem [DEPTH];

  logic        accept, isSram, isMmio, alignErr, f3Err, mmioErr, err;
  logic        accessDone, leaveAccess, sramWr;
  logic [1:0]  off;
  logic [3:0]  byteEn;
  logic [31:0] wdataSh, srcWord, shifted, loadData, mmioRdata;
  logic        unusedBits;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  assign off      = rq.addr[1:0];
  assign isSram   = !rq.addr[31] && rq.addr[28];
  assign isMmio   = rq.addr[31];
  assign alignErr = (((rq.funct3 == 3'b001) || (rq.funct3 == 3'b101)) && off[0]) ||
                    ((rq.funct3 == 3'b010) && (off != 2'b00));
  assign f3Err    = rq.we ? (rq.funct3 > 3'b010)
                          : ((rq.funct3 == 3'b011) || (rq.funct3 > 3'b101));
  assign err      = !(isSram || isMmio) || alignErr || f3Err || (isMmio && mmioErr);

  assign unusedBits = ^{rq.addr[30:29], rq.addr[27:ADDR_W+2]};

  // Stores and errors spend a single cycle in ACCESS; loads wait out the read latency.
  assign accessDone  = (rq.we || err) ? 1'b1 : (latCnt == 2'(READ_LAT - 1));
  assign leaveAccess = (state == ACCESS) && accessDone;
  assign sramWr      = leaveAccess && rq.we && isSram && !err;

  assign byteEn  = 4'(rq.mask << off);
  assign wdataSh = rq.wdata << {off, 3'b000};

`ifdef MMIO_COUNTERS_EN
  logic [31:0] cycleCnt, storeCnt;
  logic        clrCnt;

  assign clrCnt    = leaveAccess && rq.we && isMmio && !err;
  assign mmioErr   = rq.we ? (rq.addr != 32'h8000_0018)
                           : ((rq.addr != 32'h8000_0010) && (rq.addr != 32'h8000_0014));
  assign mmioRdata = (rq.addr == 32'h8000_0010) ? cycleCnt : storeCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt <= '0;
      storeCnt <= '0;
    end else if (clrCnt) begin
      cycleCnt <= '0;
      storeCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (sramWr) storeCnt <= storeCnt + 32'd1;
    end
  end
`else
  assign mmioErr   = 1'b0;
  assign mmioRdata = '0;
`endif

  assign srcWord = isMmio ? mmioRdata : rdWord;
  assign shifted = srcWord >> {off, 3'b000};

  always_comb begin
    loadData = '0;
    case (rq.funct3)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  loadData = shifted;
      3'b100:  loadData = {24'd0, shifted[7:0]};
      3'b101:  loadData = {16'd0, shifted[15:0]};
      default: loadData = '0;
    endcase
  end

  // SRAM has no reset: the read port is sampled at acceptance, the write lands when leaving ACCESS.
  always_ff @(posedge clk) begin
    if (sramWr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[rq.addr[ADDR_W+1:2]][8*b +: 8] <= wdataSh[8*b +: 8];
      end
    end
    if (accept) rdWord <= mem[req_addr[ADDR_W+1:2]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      latCnt     <= '0;
      rq         <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= ACCESS;
            latCnt <= '0;
            rq     <= '{we: req_we, addr: req_addr, wdata: req_wdata,
                        mask: req_mask, funct3: req_funct3};
          end
        end
        ACCESS: begin
          if (accessDone) begin
            state      <= RESP;
            resp_err   <= err;
            resp_rdata <= (err || rq.we) ? 32'd0 : loadData;
          end else begin
            latCnt <= latCnt + 2'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_resp_unit.sv
// Directed bench for mem_resp_unit: hand-computed load/store results, latency, errors, reset abort.
module tb_mem_resp_unit;
  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_mask = '0;
  logic [2:0]  req_funct3 = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int numChecks = 0;
  int numErrors = 0;

  always #5 clk = ~clk;

  mem_resp_unit #(.DEPTH(1024), .ADDR_W(10), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .req_funct3(req_funct3), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic doReq(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [2:0] f3,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int width);
    int  guard;
    bit  got;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_mask = mask; req_funct3 = f3;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkVal("readyTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) got = 1'b1;
    end
    if (!got) checkVal("respTimeout", 32'd0, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
    width = resp_valid ? 2 : 1;
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask, input logic [2:0] f3,
                      input logic [31:0] expData, input logic expErr);
    logic [31:0] rd;
    logic        e;
    int          lat, width;
    doReq(we, addr, wdata, mask, f3, rd, e, lat, width);
    checkVal({tag, ".data"}, rd, expData);
    checkVal({tag, ".err"}, {31'd0, e}, {31'd0, expErr});
    checkVal({tag, ".lat"}, lat, (we || expErr) ? 2 : RL + 1);
    checkVal({tag, ".pulse"}, width, 1);
  endtask

  logic [31:0] rdv;
  logic        ev;
  int          lv, wv;
  bit          sawValid;

  initial begin
    repeat (3) @(negedge clk);
    checkVal("rst.ready", {31'd0, req_ready}, 1);
    checkVal("rst.valid", {31'd0, resp_valid}, 0);
    checkVal("rst.rdata", resp_rdata, 0);
    checkVal("rst.err", {31'd0, resp_err}, 0);
    rst_n = 1'b1;

    xact("swBase",  1, 32'h1000_0000, 32'h1234_5678, 4'hF, 3'b010, 32'h0, 0);
    xact("swBeef",  1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'b010, 32'h0, 0);
    xact("lwBeef",  0, 32'h1000_0004, 32'h0,         4'h0, 3'b010, 32'hDEAD_BEEF, 0);
    xact("swZero",  1, 32'h1000_0004, 32'h0,         4'hF, 3'b010, 32'h0, 0);
    xact("sbAB",    1, 32'h1000_0006, 32'h0000_00AB, 4'h1, 3'b000, 32'h0, 0);
    xact("lwAB",    0, 32'h1000_0004, 32'h0,         4'h0, 3'b010, 32'h00AB_0000, 0);
    xact("lbAB",    0, 32'h1000_0006, 32'h0,         4'h0, 3'b000, 32'hFFFF_FFAB, 0);
    xact("lbuAB",   0, 32'h1000_0006, 32'h0,         4'h0, 3'b100, 32'h0000_00AB, 0);
    xact("lwAlias", 0, 32'h1000_1004, 32'h0,         4'h0, 3'b010, 32'h00AB_0000, 0);
    xact("lhMis",   0, 32'h1000_0003, 32'h0,         4'h0, 3'b001, 32'h0, 1);
    xact("swMis",   1, 32'h1000_0002, 32'hFFFF_FFFF, 4'hF, 3'b010, 32'h0, 1);
    xact("swMask0", 1, 32'h1000_0000, 32'hFFFF_FFFF, 4'h0, 3'b010, 32'h0, 0);
    xact("lwBase",  0, 32'h1000_0000, 32'h0,         4'h0, 3'b010, 32'h1234_5678, 0);
    xact("lhuHi",   0, 32'h1000_0002, 32'h0,         4'h0, 3'b101, 32'h0000_1234, 0);
    xact("lhLo",    0, 32'h1000_0000, 32'h0,         4'h0, 3'b001, 32'h0000_5678, 0);
    xact("shF00D",  1, 32'h1000_000A, 32'h0000_F00D, 4'h3, 3'b001, 32'h0, 0);
    xact("lhF00D",  0, 32'h1000_000A, 32'h0,         4'h0, 3'b001, 32'hFFFF_F00D, 0);
    xact("lhuF00D", 0, 32'h1000_000A, 32'h0,         4'h0, 3'b101, 32'h0000_F00D, 0);
    xact("noRegion",0, 32'h0000_0100, 32'h0,         4'h0, 3'b010, 32'h0, 1);
    xact("ldF3Bad", 0, 32'h1000_0000, 32'h0,         4'h0, 3'b011, 32'h0, 1);
    xact("stF3Bad", 1, 32'h1000_0000, 32'hFFFF_FFFF, 4'hF, 3'b100, 32'h0, 1);
    xact("lwAfter", 0, 32'h1000_0000, 32'h0,         4'h0, 3'b010, 32'h1234_5678, 0);

`ifdef MMIO_COUNTERS_EN
    xact("clr0",    1, 32'h8000_0018, 32'h0, 4'hF, 3'b010, 32'h0, 0);
    xact("st1",     1, 32'h1000_0010, 32'h1, 4'hF, 3'b010, 32'h0, 0);
    xact("st2",     1, 32'h1000_0014, 32'h2, 4'h0, 3'b010, 32'h0, 0);
    xact("stCnt2",  0, 32'h8000_0014, 32'h0, 4'h0, 3'b010, 32'd2, 0);
    xact("clr1",    1, 32'h8000_0018, 32'h0, 4'hF, 3'b010, 32'h0, 0);
    doReq(0, 32'h8000_0010, 32'h0, 4'h0, 3'b010, rdv, ev, lv, wv);
    checkVal("cycSmall", {31'd0, rdv < 32'd6}, 1);
    checkVal("cycErr", {31'd0, ev}, 0);
    xact("stCnt0",  0, 32'h8000_0014, 32'h0, 4'h0, 3'b010, 32'd0, 0);
    xact("mmioBad", 0, 32'h8000_0020, 32'h0, 4'h0, 3'b010, 32'h0, 1);
`else
    xact("mmioLd",  0, 32'h8000_0010, 32'h0, 4'h0, 3'b010, 32'h0, 0);
    xact("mmioSt",  1, 32'h8000_0018, 32'hFFFF_FFFF, 4'hF, 3'b010, 32'h0, 0);
`endif

    // Abort a load mid-ACCESS with an asynchronous reset.
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h1000_0004; req_mask = 4'h0; req_funct3 = 3'b010;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkVal("abort.ready", {31'd0, req_ready}, 1);
    checkVal("abort.valid", {31'd0, resp_valid}, 0);
    sawValid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) sawValid = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) sawValid = 1'b1;
    end
    checkVal("abort.noResp", {31'd0, sawValid}, 0);
    xact("lwPostRst", 0, 32'h1000_0004, 32'h0, 4'h0, 3'b010, 32'h00AB_0000, 0);

    $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_resp_unit.md
Name: mem_resp_unit

Overview:
- Memory-side responder for the pipeline's load/store port.
- Accepts one request at a time: address, write enable, unshifted byte mask (0001/0011/1111), write data and funct3.
- Decodes the region, aligns the mask and data to the address, and performs byte-masked writes to an internal data SRAM.
- Returns sign- or zero-extended load data after a fixed read latency, with optional memory-mapped counters.

Parameters:
- DEPTH, 1024, SRAM depth in 32-bit words (power of 2).
- ADDR_W, 10, log2(DEPTH).
- READ_LAT, 1, cycles spent in ACCESS for reads (legal range 1..4).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, unshifted (LSB-aligned).
- req_mask  in  4  unshifted byte mask from decode.
- req_funct3  in  3  RISC-V load/store funct3.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; region, alignment or funct3 error.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Counters are cleared; SRAM contents are not cleared.
  - Reset mid-operation abandons the pending response; no resp_valid is produced for it.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - req_ready=1 only in IDLE. All request fields are latched at acceptance.
- States:
  - IDLE -> ACCESS on acceptance.
  - ACCESS holds READ_LAT cycles for a load, 1 cycle for a store or an error, then -> RESP.
  - RESP asserts resp_valid for exactly 1 cycle -> IDLE.
  - Minimum load latency from acceptance edge to resp_valid is READ_LAT+1 cycles; a store takes 2 cycles.
- Region decode:
  - addr[31]=0 and addr[28]=1: SRAM. Word index = addr[ADDR_W+1:2]; higher bits are ignored and alias.
  - addr[31]=1: MMIO.
  - Otherwise: resp_err=1, no side effect.
- Alignment:
  - Funct3 001/101 with addr[0]=1 is an error.
  - Funct3 010 with addr[1:0]!=0 is an error.
  - Errors perform no write and return rdata=0.
- Store:
  - Byte enables = req_mask << addr[1:0]; data = req_wdata << (8*addr[1:0]).
  - SRAM is written on the edge leaving ACCESS.
  - req_mask=0000 is a legal no-op and acks with err=0.
  - Legal store funct3 values are 000, 001, 010; anything else is an error.
- Load:
  - Word read, then right-shifted by 8*addr[1:0].
  - 000 LB sign-extends bit 7; 001 LH sign-extends bit 15; 010 LW returns the full word.
  - 100 LBU and 101 LHU zero-extend.
  - Any other funct3 is an error.
- Back-to-back: a new request can be accepted in the cycle after RESP (IDLE). A store followed by a load to the same address returns the new data.

Optional Feature:
- MMIO_COUNTERS_EN defined:
  - cycle_cnt (32-bit) increments every cycle and wraps at 0xFFFFFFFF->0; read at 0x80000010.
  - store_cnt increments on each successful SRAM store (including mask 0000); read at 0x80000014.
  - A store to 0x80000018 clears both counters; a clear in the same cycle as an increment wins.
  - Any other MMIO address returns err=1.
- Not defined: MMIO loads return 0 with err=0, MMIO stores are ignored, and no counter logic exists.

Test Plan:
- SW 0xDEADBEEF @0x10000004, then LW @0x10000004 -> rdata=0xDEADBEEF, err=0; load resp_valid exactly READ_LAT+1 cycles after acceptance.
- SB 0x000000AB @0x10000006 over word 0 -> LW @0x10000004 = 0x00AB0000; LB @0x10000006 = 0xFFFFFFAB; LBU = 0x000000AB.
- LH @0x10000003 and SW @0x10000002 -> err=1, rdata=0; the word at 0x10000000 is unchanged.
- Load @0x00000100 (no region) -> err=1; funct3=011 load @0x10000000 -> err=1.
- Assert rst_n=0 during ACCESS of a load -> no resp_valid, req_ready=1 immediately; a later LW still returns the previously stored data.
- With MMIO_COUNTERS_EN: two SRAM stores then LW @0x80000014 -> 2; SW @0x80000018 then LW @0x80000010 -> small value (<6) and LW @0x80000014 -> 0.
